hazard_tnew_tracker: RTL and testbench
======================================

Name: hazard_tnew_tracker

Overview:
- Producer-side companion to the pipeline's forwarding mux logic. It records every in-flight register write (destination address, write enable, Tnew) as instructions move from E to M to W.
- It tells the D stage two things: whether it must stall, and which stage each D source operand should be forwarded from.
- Sits beside the D/E, E/M and M/W pipeline registers. It drives the stall and bubble-insert controls and the per-operand forward-select codes consumed downstream.

Parameters:
- REG_AW, 5, register-address width.
- TNEW_W, 2, width of Tnew/Tuse counters (max value 3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a clk edge clears all state.
- D_A1  in  REG_AW  rs address of the instruction in D.
- D_A2  in  REG_AW  rt address of the instruction in D.
- D_A1use  in  1  D instruction reads A1.
- D_A2use  in  1  D instruction reads A2.
- D_Tuse1  in  TNEW_W  cycles until the A1 value is consumed (0 = needed in D).
- D_Tuse2  in  TNEW_W  cycles until the A2 value is consumed.
- D_A3  in  REG_AW  destination register of the D instruction.
- D_RegWrite  in  1  D instruction writes A3.
- D_Tnew  in  TNEW_W  cycles after entering E until the result is forwardable.
- stall  out  1  freeze PC and the F/D register; insert a bubble into E.
- fwd_sel1  out  2  source for D_A1: 0 regfile, 1 E, 2 M, 3 W.
- fwd_sel2  out  2  source for D_A2, same encoding.
- E_A3, M_A3, W_A3  out  REG_AW each  tracked destination per stage.
- E_RegWrite, M_RegWrite, W_RegWrite  out  1 each  tracked write enable per stage (0 if the address is 0).
- E_ready, M_ready  out  1 each  stage's Tnew == 0, so its result may be forwarded.

Behaviour:
- State: three entries E, M, W. Each holds {A3, RegWrite, Tnew}. Tnew in W is always 0.
- Reset (reset==0 at an edge): all A3=0, RegWrite=0, Tnew=0. Consequently stall=0, fwd_sel1/2=0, E_ready=M_ready=1. Reset overrides any advance or stall in the same cycle.
- Entry capture: RegWrite is captured as D_RegWrite && (D_A3 != 0). Writes to $0 are never tracked.
- Every edge, unconditionally:
  - W <= M.
  - M <= {E.A3, E.RegWrite, satdec(E.Tnew)}, where satdec(x) = (x == 0) ? 0 : x - 1.
- Every edge, E depends on stall:
  - stall == 0: E <= {D_A3, captured RegWrite, D_Tnew}.
  - stall == 1: E <= bubble {0, 0, 0}.
- Match for source k (k = 1, 2): Ak_use && Ak != 0, searched youngest first (E, then M, then W).
  - The first stage with RegWrite && A3 == Ak is the producer. Older matches are ignored.
- Stall, combinational from current state and D inputs:
  - stall = OR over k of (producer exists && producer.Tnew > D_Tusek).
- Forward select, combinational:
  - fwd_selk = the producer stage code, or 0 if there is no producer.
  - It is reported even while stall == 1; consumers ignore it under stall.
- Simultaneous hazards on A1 and A2 OR into a single stall.
- The same register written in E and M: E wins.
- Latency: all outputs are combinational from registered state. Updated tracking is visible the cycle after the edge.
- Tnew ≥ 1 in W is illegal input. W-stage Tnew is forced to 0 regardless.

Optional Feature:
- Macro HAZARD_MDU_BUSY_EN.
- When defined, adds two inputs:
  - MDU_busy (in, 1): the multiply/divide unit is mid-operation.
  - D_isMD (in, 1): the D instruction uses the MDU.
- With the macro, stall additionally asserts when MDU_busy && D_isMD. This is an OR with the Tnew stall and inserts a bubble the same way.
- Without the macro, those ports do not exist and stall is the Tnew rule only.

Decomposition:
- Shared package/header holds:
  - FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3.
  - TUSE/TNEW constants per instruction class.
  - The stage-entry record layout.
- One sub-module, hazard_src_match: per-source youngest-match priority, stall term and sel code. Instantiated twice.

Test Plan:
- After reset, then reset=1 with no writes in flight: stall=0, fwd_sel1=fwd_sel2=0, E_ready=M_ready=1.
- lw $8 enters with D_Tnew=2, RegWrite=1. Next cycle D has A1=8, Tuse1=0 → stall=1 for 2 cycles (bubbles in E). Third cycle: stall=0, fwd_sel1=3 (W).
- addu $9 enters with Tnew=1. Next cycle beq uses A1=9, Tuse1=0 → stall=1 for one cycle, then fwd_sel1=2 (M).
- $5 written in both E (Tnew 0) and M. D reads A2=5 with Tuse2=1 → stall=0, fwd_sel2=1.
- D reads A1=0 while E has A3=0 with D_RegWrite=1 → E_RegWrite=0, fwd_sel1=0, stall=0.
- Reset driven low during a stall → all state clears next edge; stall=0 the following cycle.

Source files
------------

// File: rtl/hazard_tnew_tracker_pkg.sv
// hazard_tnew_tracker_pkg
// Shared definitions for the Tnew/Tuse hazard tracker:
//   - register-address and Tnew/Tuse widths
//   - forward-select codes (FWD_RF/FWD_E/FWD_M/FWD_W)
//   - Tuse/Tnew constants per instruction class
//   - the per-stage tracking record and its saturating-decrement helper
package hazard_tnew_tracker_pkg;

  localparam int REG_AW = 5;
  localparam int TNEW_W = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // Consumer side: cycles from D until an operand is actually needed.
  localparam logic [TNEW_W-1:0] TUSE_BRANCH = 2'd0;  // compare in D
  localparam logic [TNEW_W-1:0] TUSE_ALU    = 2'd1;  // ALU operand in E
  localparam logic [TNEW_W-1:0] TUSE_STORE  = 2'd2;  // store data in M

  // Producer side: cycles after entering E until the result is forwardable.
  localparam logic [TNEW_W-1:0] TNEW_NONE = 2'd0;
  localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;
  localparam logic [TNEW_W-1:0] TNEW_MDU  = 2'd3;

  localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};
  localparam logic [TNEW_W-1:0] TNEW_ZERO = {TNEW_W{1'b0}};
  localparam logic [TNEW_W-1:0] TNEW_ONE  = {{(TNEW_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [REG_AW-1:0] a3;
    logic              reg_write;
    logic [TNEW_W-1:0] tnew;
  } stage_entry_t;

  localparam stage_entry_t ENTRY_BUBBLE = '{a3: REG_ZERO, reg_write: 1'b0, tnew: TNEW_ZERO};

  // Tnew counts down by one per stage and holds at zero.
  function automatic logic [TNEW_W-1:0] satdec(input logic [TNEW_W-1:0] x);
    return (x == TNEW_ZERO) ? TNEW_ZERO : (x - TNEW_ONE);
  endfunction

endpackage

// File: rtl/hazard_tnew_tracker_if.sv
// hazard_tnew_tracker_if
// Bundles the D-stage request (source/destination addresses, use flags,
// Tuse/Tnew) and the tracker's responses (stall, forward selects, per-stage
// tracking state). slave = tracker side, master = pipeline/driver side.
// With HAZARD_MDU_BUSY_EN defined, MDU_busy and D_isMD are added.
interface hazard_tnew_tracker_if;
  import hazard_tnew_tracker_pkg::*;

  logic [REG_AW-1:0] D_A1;
  logic [REG_AW-1:0] D_A2;
  logic              D_A1use;
  logic              D_A2use;
  logic [TNEW_W-1:0] D_Tuse1;
  logic [TNEW_W-1:0] D_Tuse2;
  logic [REG_AW-1:0] D_A3;
  logic              D_RegWrite;
  logic [TNEW_W-1:0] D_Tnew;
`ifdef HAZARD_MDU_BUSY_EN
  logic              MDU_busy;
  logic              D_isMD;
`endif

  logic              stall;
  logic [1:0]        fwd_sel1;
  logic [1:0]        fwd_sel2;
  logic [REG_AW-1:0] E_A3;
  logic [REG_AW-1:0] M_A3;
  logic [REG_AW-1:0] W_A3;
  logic              E_RegWrite;
  logic              M_RegWrite;
  logic              W_RegWrite;
  logic              E_ready;
  logic              M_ready;

`ifdef HAZARD_MDU_BUSY_EN
  modport slave (
    input  D_A1, D_A2, D_A1use, D_A2use, D_Tuse1, D_Tuse2, D_A3, D_RegWrite, D_Tnew,
    input  MDU_busy, D_isMD,
    output stall, fwd_sel1, fwd_sel2, E_A3, M_A3, W_A3,
    output E_RegWrite, M_RegWrite, W_RegWrite, E_ready, M_ready
  );
  modport master (
    output D_A1, D_A2, D_A1use, D_A2use, D_Tuse1, D_Tuse2, D_A3, D_RegWrite, D_Tnew,
    output MDU_busy, D_isMD,
    input  stall, fwd_sel1, fwd_sel2, E_A3, M_A3, W_A3,
    input  E_RegWrite, M_RegWrite, W_RegWrite, E_ready, M_ready
  );
`else
  modport slave (
    input  D_A1, D_A2, D_A1use, D_A2use, D_Tuse1, D_Tuse2, D_A3, D_RegWrite, D_Tnew,
    output stall, fwd_sel1, fwd_sel2, E_A3, M_A3, W_A3,
    output E_RegWrite, M_RegWrite, W_RegWrite, E_ready, M_ready
  );
  modport master (
    output D_A1, D_A2, D_A1use, D_A2use, D_Tuse1, D_Tuse2, D_A3, D_RegWrite, D_Tnew,
    input  stall, fwd_sel1, fwd_sel2, E_A3, M_A3, W_A3,
    input  E_RegWrite, M_RegWrite, W_RegWrite, E_ready, M_ready
  );
`endif

endinterface

// File: rtl/hazard_tnew_tracker_src_match.sv
// hazard_src_match
// Per-source producer search. Looks for the youngest in-flight writer of
// src_a (E, then M, then W) and reports its forward-select code and whether
// its Tnew exceeds the consumer's Tuse (stall term).
// Ports: src_a/src_use/src_tuse describe the D operand; e_ent/m_ent/w_ent
// are the tracked stage records; src_stall/src_sel are the results.
module hazard_src_match
  import hazard_tnew_tracker_pkg::*;
(
  input  logic [REG_AW-1:0] src_a,
  input  logic              src_use,
  input  logic [TNEW_W-1:0] src_tuse,
  input  stage_entry_t      e_ent,
  input  stage_entry_t      m_ent,
  input  stage_entry_t      w_ent,
  output logic              src_stall,
  output logic [1:0]        src_sel
);

  logic active_s;
  logic hit_e_s;
  logic hit_m_s;
  logic hit_w_s;

  // Hit detection: $0 and unused operands never match a producer.
  always_comb begin
    active_s = src_use && (src_a != REG_ZERO);
    hit_e_s  = active_s && e_ent.reg_write && (e_ent.a3 == src_a);
    hit_m_s  = active_s && m_ent.reg_write && (m_ent.a3 == src_a);
    hit_w_s  = active_s && w_ent.reg_write && (w_ent.a3 == src_a);
  end

  // Youngest-first priority: an E hit masks older M/W writers of the same register.
  always_comb begin
    src_stall = 1'b0;
    src_sel   = FWD_RF;
    if (hit_e_s) begin
      src_sel   = FWD_E;
      src_stall = (e_ent.tnew > src_tuse);
    end else if (hit_m_s) begin
      src_sel   = FWD_M;
      src_stall = (m_ent.tnew > src_tuse);
    end else if (hit_w_s) begin
      src_sel   = FWD_W;
      src_stall = (w_ent.tnew > src_tuse);
    end else begin
      src_sel   = FWD_RF;
      src_stall = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_tnew_tracker.sv
// hazard_tnew_tracker
// Tracks in-flight register writes through E, M and W ({A3, RegWrite, Tnew})
// and tells D whether to stall and where each source operand should be
// forwarded from. Outputs are combinational from registered state and the
// current D inputs.
// Ports: clk (rising edge), reset (synchronous, active-low), bus (slave
// modport of hazard_tnew_tracker_if: D request in, stall/forward/tracking out).
// Optional: define HAZARD_MDU_BUSY_EN to also stall MDU instructions in D
// while the multiply/divide unit is busy.
module hazard_tnew_tracker
  import hazard_tnew_tracker_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  hazard_tnew_tracker_if.slave   bus
);

  stage_entry_t e_r;
  stage_entry_t m_r;
  stage_entry_t w_r;

  logic         d_reg_write_s;
  logic         stall1_s;
  logic         stall2_s;
  logic [1:0]   sel1_s;
  logic [1:0]   sel2_s;
  logic         stall_s;

  hazard_src_match u_match1 (
    .src_a     (bus.D_A1),
    .src_use   (bus.D_A1use),
    .src_tuse  (bus.D_Tuse1),
    .e_ent     (e_r),
    .m_ent     (m_r),
    .w_ent     (w_r),
    .src_stall (stall1_s),
    .src_sel   (sel1_s)
  );

  hazard_src_match u_match2 (
    .src_a     (bus.D_A2),
    .src_use   (bus.D_A2use),
    .src_tuse  (bus.D_Tuse2),
    .e_ent     (e_r),
    .m_ent     (m_r),
    .w_ent     (w_r),
    .src_stall (stall2_s),
    .src_sel   (sel2_s)
  );

  // Writes to $0 are dropped at capture, so no stage ever tracks them.
  always_comb begin
    d_reg_write_s = bus.D_RegWrite && (bus.D_A3 != REG_ZERO);
  end

  // Combined stall: either operand hazard (plus MDU busy when built in).
  always_comb begin
`ifdef HAZARD_MDU_BUSY_EN
    stall_s = stall1_s || stall2_s || (bus.MDU_busy && bus.D_isMD);
`else
    stall_s = stall1_s || stall2_s;
`endif
  end

  // Pipeline advance: M and W always shift; E takes D or a bubble on stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_r <= ENTRY_BUBBLE;
      m_r <= ENTRY_BUBBLE;
      w_r <= ENTRY_BUBBLE;
    end else begin
      // A result reaching W is always forwardable, whatever was tracked in M.
      w_r <= '{a3: m_r.a3, reg_write: m_r.reg_write, tnew: TNEW_ZERO};
      m_r <= '{a3: e_r.a3, reg_write: e_r.reg_write, tnew: satdec(e_r.tnew)};
      if (stall_s) begin
        e_r <= ENTRY_BUBBLE;
      end else begin
        e_r <= '{a3: bus.D_A3, reg_write: d_reg_write_s, tnew: bus.D_Tnew};
      end
    end
  end

  assign bus.stall      = stall_s;
  assign bus.fwd_sel1   = sel1_s;
  assign bus.fwd_sel2   = sel2_s;
  assign bus.E_A3       = e_r.a3;
  assign bus.M_A3       = m_r.a3;
  assign bus.W_A3       = w_r.a3;
  assign bus.E_RegWrite = e_r.reg_write;
  assign bus.M_RegWrite = m_r.reg_write;
  assign bus.W_RegWrite = w_r.reg_write;
  assign bus.E_ready    = (e_r.tnew == TNEW_ZERO);
  assign bus.M_ready    = (m_r.tnew == TNEW_ZERO);

endmodule

// File: tb/tb_hazard_tnew_tracker.sv
// tb_hazard_tnew_tracker
// Directed scoreboard bench: each stimulus cycle pushes a hand-computed
// expected response; a negedge monitor pops and compares.
// Expected vector fields: {stall, fwd_sel1, fwd_sel2, E_A3, E_RegWrite, E_ready, M_ready}.
module tb_hazard_tnew_tracker;

  logic clk;
  logic reset;

  hazard_tnew_tracker_if bus_if ();

  hazard_tnew_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] exp_q[$];
  string       tag_q[$];
  int          checks;
  int          errors;

  // Monitor: sample outputs half a cycle after the stimulus edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] act;
      logic [12:0] exp_v;
      string       tag;
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      act   = {bus_if.stall, bus_if.fwd_sel1, bus_if.fwd_sel2, bus_if.E_A3,
               bus_if.E_RegWrite, bus_if.E_ready, bus_if.M_ready};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s: actual stall=%b sel1=%0d sel2=%0d E_A3=%0d E_RW=%b E_rdy=%b M_rdy=%b, required stall=%b sel1=%0d sel2=%0d E_A3=%0d E_RW=%b E_rdy=%b M_rdy=%b",
                 tag, act[12], act[11:10], act[9:8], act[7:3], act[2], act[1], act[0],
                 exp_v[12], exp_v[11:10], exp_v[9:8], exp_v[7:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic drive(input logic [4:0] a1, input logic u1, input logic [1:0] t1,
                       input logic [4:0] a2, input logic u2, input logic [1:0] t2,
                       input logic [4:0] a3, input logic rw, input logic [1:0] tnew);
    bus_if.D_A1       = a1;
    bus_if.D_A1use    = u1;
    bus_if.D_Tuse1    = t1;
    bus_if.D_A2       = a2;
    bus_if.D_A2use    = u2;
    bus_if.D_Tuse2    = t2;
    bus_if.D_A3       = a3;
    bus_if.D_RegWrite = rw;
    bus_if.D_Tnew     = tnew;
  endtask

  task automatic expect_out(input string tag, input logic st, input logic [1:0] s1,
                            input logic [1:0] s2, input logic [4:0] ea3, input logic erw,
                            input logic erdy, input logic mrdy);
    exp_q.push_back({st, s1, s2, ea3, erw, erdy, mrdy});
    tag_q.push_back(tag);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
`ifdef HAZARD_MDU_BUSY_EN
    bus_if.MDU_busy = 1'b0;
    bus_if.D_isMD   = 1'b0;
`endif
    drive(5'd8, 1'b1, 2'd0, 5'd8, 1'b1, 2'd0, 5'd8, 1'b1, 2'd3);
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state, then lw $8 (Tnew 2) enters
    reset = 1'b1;
    drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd8, 1'b1, 2'd2);
    expect_out("reset_state", 1'b0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1);

    // Consumer of $8 with Tuse 0: two stall cycles, then forward from W
    next_cycle();
    drive(5'd8, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
    expect_out("lw_stall_E", 1'b1, 2'd1, 2'd0, 5'd8, 1'b1, 1'b0, 1'b1);
    next_cycle();
    expect_out("lw_stall_M", 1'b1, 2'd2, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    expect_out("lw_fwd_W", 1'b0, 2'd3, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1);

    // addu $9 (Tnew 1), then beq on $9 with Tuse 0
    next_cycle();
    drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd9, 1'b1, 2'd1);
    expect_out("addu_enter", 1'b0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    drive(5'd9, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
    expect_out("beq_stall", 1'b1, 2'd1, 2'd0, 5'd9, 1'b1, 1'b0, 1'b1);
    next_cycle();
    expect_out("beq_fwd_M", 1'b0, 2'd2, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1);

    // $5 written with Tnew 3 then Tnew 0: E (ready) must win over M (Tnew 2)
    next_cycle();
    drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 2'd3);
    expect_out("w5_first", 1'b0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 2'd0);
    expect_out("w5_second", 1'b0, 2'd0, 2'd0, 5'd5, 1'b1, 1'b0, 1'b1);
    next_cycle();
    drive(5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0);
    expect_out("e_wins_over_m", 1'b0, 2'd0, 2'd1, 5'd5, 1'b1, 1'b1, 1'b0);

    // Write to $0 is not tracked; reads of $0 never forward or stall
    next_cycle();
    drive(5'd0, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b1, 2'd2);
    expect_out("zero_write", 1'b0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    drive(5'd0, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
    expect_out("zero_untracked", 1'b0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    // $7 (Tnew 1) then a hazard on A2 only; reset asserted during the stall
    next_cycle();
    drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd7, 1'b1, 2'd1);
    expect_out("w7_enter", 1'b0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    reset = 1'b0;
    drive(5'd3, 1'b1, 2'd0, 5'd7, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0);
    expect_out("a2_stall_in_reset", 1'b1, 2'd0, 2'd1, 5'd7, 1'b1, 1'b0, 1'b1);
    next_cycle();
    reset = 1'b1;
    expect_out("after_reset", 1'b0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
